alu_decode_stage: RTL
=====================

# alu_decode_stage

Registered decode stage that sits between instruction fetch and `ALU`: accepts one 32-bit RV32I instruction plus PC per valid/ready handshake, reads rs1/rs2 through a combinational register-file port, and presents `A`, `B`, `operation` and destination info for `ALU`. Covers the integer register-register (OP), register-immediate (OP-IMM), LUI and AUIPC classes. Other encodings are flagged illegal. A 2-entry skid buffer gives full throughput under downstream backpressure.

## Interface
- `DATA_WIDTH`, 32, operand/PC width
- `REG_ADDR_WIDTH`, 5, register index width
- `clk`  in  1  clock; all state on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `in_valid` / `in_ready`  in / out  1  fetch handshake
- `in_instr`  in  32  instruction word
- `in_pc`  in  DATA_WIDTH  PC of `in_instr`
- `rs1_addr`, `rs2_addr`  out  REG_ADDR_WIDTH  combinational from `in_instr[19:15]`, `[24:20]`
- `rs1_data`, `rs2_data`  in  DATA_WIDTH  same-cycle register-file read data
- `flush`  in  1  discard all held and incoming instructions
- `out_valid` / `out_ready`  out / in  1  ALU-side handshake
- `out_a`, `out_b`  out  DATA_WIDTH  ALU operands A, B
- `out_op`  out  alu_operation_type  ALU operation
- `out_rd`  out  REG_ADDR_WIDTH  destination register
- `out_rd_we`  out  1  writeback enable (0 for rd=x0 or illegal)
- `out_illegal`  out  1  undecodable instruction
- `out_pc`  out  DATA_WIDTH  PC passthrough

## Operation
- Accept when `in_valid && in_ready`; decode and capture `rs*_data` that cycle.
- Opcode `[1:0]!=2'b11` → illegal.
- OP (0110011), A=rs1, B=rs2. funct7=0000000, funct3 000..111 → ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND. funct7=0100000 with funct3 000 → SUB, 101 → SRA. Any other funct7/funct3 combination → illegal.
- For SLL/SRL/SRA from OP, B={27'b0, rs2_data[4:0]}.
- OP-IMM (0010011), A=rs1, B=sign-extended `instr[31:20]`. funct3 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
- OP-IMM shifts take B=`{27'b0, instr[24:20]}`: 001 requires funct7=0000000 → SLL; 101 with funct7 0000000 → SRL, 0100000 → SRA. Else illegal.
- LUI (0110111): A=0, B=`{12'b0, instr[31:12]}` (ALU shifts left 12), op LUI.
- AUIPC (0010111): A=in_pc, B=`{instr[31:12],12'b0}`, op AUIPC.
- Any other opcode → illegal.
- Illegal: A=B=0, op ADD, rd_we=0, illegal=1; still handed downstream in order.
- `out_rd_we = legal && rd!=0`.
- No hazard detection or forwarding in this block.

## Timing
- Latency 1: accepted in cycle N → `out_valid` in N+1. Throughput 1/cycle while `out_ready` high.
- Output slot holds while `out_valid && !out_ready`; payload stable until taken.
- Skid: accept while output slot stalled → entry goes to skid register; `in_ready` (registered) falls next cycle. When output drains, skid moves to output slot and `in_ready` rises next cycle. Order always preserved; no drop or duplication.
- `flush`: next cycle `out_valid=0`, skid empty, `in_ready=1`. Flush wins over a simultaneous accept (entry discarded) and over a simultaneous output transfer (transfer still counts downstream).
- Reset: `out_valid=0`, `in_ready=1`, skid empty, `out_a/out_b/out_pc=0`, `out_op=ADD`, `out_rd=0`, `out_rd_we=0`, `out_illegal=0`. Handshakes during `rst` cycles are ignored. Reset mid-stall discards both entries.

## Structure
- In `common`: opcode constants (OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC), funct7 constants, packed struct `alu_issue_t` {a, b, op, rd, rd_we, illegal, pc}; reuse existing `alu_operation_type`.
- Pure decode in a combinational function.
- One sub-module: `skid_buffer` parameterized on payload type, owning the two `alu_issue_t` registers plus valid bits, flush and ready logic.

## Test plan
- `0x002081B3` (add x3,x1,x2), rs1=5, rs2=7 → next cycle a=5, b=7, op ADD, rd=3, rd_we=1.
- `0x123452B7` (lui x5,0x12345) → a=0, b=0x00012345, op LUI. Then `0xFFF00093` (addi x1,x0,-1) → b=0xFFFFFFFF, op ADD.
- `0x40315093` (srai x1,x2,3), rs1=0x80000000 → op SRA, b=3. Register SLL with rs2=0x25 → b=5.
- out_ready low, 3 back-to-back instrs → first held, second in skid, in_ready low. Release → all three out in order, one per cycle, none duplicated.
- Skid full plus `flush` with `in_valid` high → next cycle out_valid=0, in_ready=1. Next accepted instruction emerges normally.
- `0x0000006F` (jal) and `0x022081B3` (funct7=0000001) → illegal=1, rd_we=0, op ADD, a=b=0. rd=x0 legal add → rd_we=0.

Source files
------------

// File: rtl/alu_decode_stage_pkg.sv
// Shared types and decode logic for the RV32I integer decode stage.
// Covers OP, OP-IMM, LUI and AUIPC. Any other encoding decodes as illegal.
package alu_decode_stage_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_LUI   = 4'd10,
    ALU_AUIPC = 4'd11
  } alu_operation_type;

  typedef struct packed {
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    alu_operation_type op;
    logic [REG_AW-1:0] rd;
    logic              rd_we;
    logic              illegal;
    logic [XLEN-1:0]   pc;
  } alu_issue_t;

  // Shift amounts are zero-extended 5-bit values; the ALU sees only those bits.
  function automatic logic [XLEN-1:0] shamt_ext(input logic [4:0] sh);
    return {{(XLEN-5){1'b0}}, sh};
  endfunction

  function automatic alu_issue_t decode_instr(
    input logic [31:0]     instr,
    input logic [XLEN-1:0] pc,
    input logic [XLEN-1:0] rs1,
    input logic [XLEN-1:0] rs2
  );
    alu_issue_t r;
    logic       legal;
    logic [6:0] f7;
    logic [2:0] f3;
    f7    = instr[31:25];
    f3    = instr[14:12];
    r     = '0;
    r.pc  = pc;
    r.rd  = instr[11:7];
    r.op  = ALU_ADD;
    legal = 1'b0;
    case (instr[6:0])
      OPC_OP: begin
        r.a   = rs1;
        r.b   = rs2;
        legal = 1'b1;
        if (f7 == F7_BASE) begin
          case (f3)
            3'b000:  r.op = ALU_ADD;
            3'b001:  r.op = ALU_SLL;
            3'b010:  r.op = ALU_SLT;
            3'b011:  r.op = ALU_SLTU;
            3'b100:  r.op = ALU_XOR;
            3'b101:  r.op = ALU_SRL;
            3'b110:  r.op = ALU_OR;
            default: r.op = ALU_AND;
          endcase
        end else if (f7 == F7_ALT && f3 == 3'b000) begin
          r.op = ALU_SUB;
        end else if (f7 == F7_ALT && f3 == 3'b101) begin
          r.op = ALU_SRA;
        end else begin
          legal = 1'b0;
        end
        if (r.op == ALU_SLL || r.op == ALU_SRL || r.op == ALU_SRA)
          r.b = shamt_ext(rs2[4:0]);
      end
      OPC_OP_IMM: begin
        r.a   = rs1;
        r.b   = {{(XLEN-12){instr[31]}}, instr[31:20]};
        legal = 1'b1;
        case (f3)
          3'b000: r.op = ALU_ADD;
          3'b010: r.op = ALU_SLT;
          3'b011: r.op = ALU_SLTU;
          3'b100: r.op = ALU_XOR;
          3'b110: r.op = ALU_OR;
          3'b111: r.op = ALU_AND;
          3'b001: begin
            r.op  = ALU_SLL;
            r.b   = shamt_ext(instr[24:20]);
            legal = (f7 == F7_BASE);
          end
          default: begin
            r.b = shamt_ext(instr[24:20]);
            if (f7 == F7_BASE)     r.op = ALU_SRL;
            else if (f7 == F7_ALT) r.op = ALU_SRA;
            else                   legal = 1'b0;
          end
        endcase
      end
      OPC_LUI: begin
        r.a   = '0;
        r.b   = {{(XLEN-20){1'b0}}, instr[31:12]};
        r.op  = ALU_LUI;
        legal = 1'b1;
      end
      OPC_AUIPC: begin
        r.a   = pc;
        r.b   = {instr[31:12], 12'b0};
        r.op  = ALU_AUIPC;
        legal = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    // Illegal entries still flow downstream, neutralised so they cannot write back.
    if (!legal) begin
      r.a       = '0;
      r.b       = '0;
      r.op      = ALU_ADD;
      r.illegal = 1'b1;
      r.rd_we   = 1'b0;
    end else begin
      r.rd_we   = (r.rd != '0);
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_decode_stage_skid.sv
// Two-entry skid buffer: an output slot plus one overflow register.
// in_ready is registered and drops only once the overflow register is occupied.
module skid_buffer #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  T     out_d, out_q, skid_d, skid_q;
  logic out_vld_d, out_vld_q;
  logic skid_vld_d, skid_vld_q;
  logic in_ready_d, in_ready_q;
  logic accept, slot_free;

  always_comb begin
    accept     = in_valid && in_ready_q;
    slot_free  = !out_vld_q || out_ready;
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (slot_free) begin
      // in_ready_q is low whenever the skid is full, so no accept can collide here.
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        out_vld_d = accept;
        if (accept) out_d = in_data;
      end
    end else if (accept) begin
      skid_d     = in_data;
      skid_vld_d = 1'b1;
    end
    in_ready_d = !skid_vld_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      out_q      <= out_d;
      skid_q     <= skid_d;
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_vld_q;
  assign out_data  = out_q;

endmodule

// File: rtl/alu_decode_stage.sv
// Registered RV32I decode stage feeding the ALU: reads operands through a
// combinational register-file port and presents A/B/op/rd behind a skid buffer.
module alu_decode_stage
  import alu_decode_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_instr,
  input  logic [DATA_WIDTH-1:0]     in_pc,
  output logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  output logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  input  logic [DATA_WIDTH-1:0]     rs1_data,
  input  logic [DATA_WIDTH-1:0]     rs2_data,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_a,
  output logic [DATA_WIDTH-1:0]     out_b,
  output alu_operation_type         out_op,
  output logic [REG_ADDR_WIDTH-1:0] out_rd,
  output logic                      out_rd_we,
  output logic                      out_illegal,
  output logic [DATA_WIDTH-1:0]     out_pc
);

  alu_issue_t issue_d;
  alu_issue_t issue_q;

  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];

  always_comb begin
    issue_d = decode_instr(in_instr, in_pc, rs1_data, rs2_data);
  end

  skid_buffer #(.T(alu_issue_t)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (issue_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (issue_q)
  );

  assign out_a       = issue_q.a;
  assign out_b       = issue_q.b;
  assign out_op      = issue_q.op;
  assign out_rd      = issue_q.rd;
  assign out_rd_we   = issue_q.rd_we;
  assign out_illegal = issue_q.illegal;
  assign out_pc      = issue_q.pc;

endmodule
